// File: rtl/block_memory_responder.sv
// Block memory responder: one 128-bit line read or write at a time.
// Each access holds busywait high for LATENCY cycles, followed by one DONE cycle.
module block_memory_responder #(
    parameter int LATENCY    = 5,
    parameter int INDEX_BITS = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic         write,
    input  logic [27:0]  address,
    input  logic [127:0] writedata,
    output logic [127:0] readdata,
    output logic         busywait
);

    // state | meaning
    // IDLE  | waiting for a request; write wins over read
    // BUSY  | latched request in progress; counting down the latency
    // DONE  | one settling cycle after completion; requests ignored
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << INDEX_BITS;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic [127:0]            data_q, data_d;
    logic                    wr_q, wr_d;
    logic                    busy_q, busy_d;
    logic [127:0]            rdata_q, rdata_d;
    logic                    mem_we;
    logic [127:0]            mem_q [DEPTH];

    logic unused_addr;
    assign unused_addr = ^address[27:INDEX_BITS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (write || read) begin
                    wr_d    = write;
                    idx_d   = address[INDEX_BITS-1:0];
                    data_d  = writedata;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    if (wr_q) mem_we  = 1'b1;
                    else      rdata_d = mem_q[idx_q];
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is cleared by reset so an interrupted write leaves nothing behind.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[idx_q] <= data_q;
        end
    end

    assign readdata = rdata_q;
    assign busywait = busy_q;

endmodule

// File: tb/tb_block_memory_responder.sv
// Self-checking bench for block_memory_responder: directed scenarios plus
// randomized accesses compared against an array-based memory model.
module tb_block_memory_responder;

    localparam int LAT = 5;
    localparam int IB  = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [27:0]  address = '0;
    logic [127:0] writedata = '0;
    logic [127:0] readdata;
    logic         busywait;

    int tests  = 0;
    int failed = 0;

    logic [127:0] ref_mem [1 << IB];
    logic [127:0] ref_rdata;

    block_memory_responder #(.LATENCY(LAT), .INDEX_BITS(IB)) dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .busywait  (busywait)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < (1 << IB); i++) ref_mem[i] = '0;
        ref_rdata = '0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic access(input string tag, input bit wr, input bit rd,
                          input logic [27:0] a, input logic [127:0] d, input bit perturb);
        read = rd; write = wr; address = a; writedata = d;
        if (wr)      ref_mem[a[IB-1:0]] = d;
        else if (rd) ref_rdata = ref_mem[a[IB-1:0]];
        for (int i = 0; i < LAT; i++) begin
            @(negedge clock);
            chk({tag, "_busy_hi"}, {127'd0, busywait}, 128'd1);
            if (perturb && i == 1) begin
                read = 1'b0; write = 1'b0; address = a + 28'd1;
            end
        end
        @(negedge clock);
        chk({tag, "_busy_lo"}, {127'd0, busywait}, 128'd0);
        chk({tag, "_rdata"}, readdata, ref_rdata);
        read = 1'b0; write = 1'b0;
        @(negedge clock);
        chk({tag, "_done_lo"}, {127'd0, busywait}, 128'd0);
        @(negedge clock);
        chk({tag, "_idle_lo"}, {127'd0, busywait}, 128'd0);
        chk({tag, "_idle_rdata"}, readdata, ref_rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [27:0]  ra;
        logic [27:0]  last_wa;
        logic [127:0] rd_data;
        int           op;

        model_reset();
        last_wa = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("reset_idle_busy", {127'd0, busywait}, 128'd0);
            chk("reset_idle_rdata", readdata, 128'd0);
        end

        access("wr3", 1, 0, 28'h0000003, 128'h0123456789ABCDEF0123456789ABCDEF, 0);
        access("rd3", 0, 1, 28'h0000003, 128'd0, 0);
        access("wr105", 1, 0, 28'h0000105, {32{4'hA}}, 0);
        access("rd5_alias", 0, 1, 28'h0000005, 128'd0, 0);
        access("both10", 1, 1, 28'h0000010, {32{4'h5}}, 0);
        access("rd10", 0, 1, 28'h0000010, 128'd0, 0);
        access("wr20", 1, 0, 28'h0000020, 128'hDEADBEEF_00000020_CAFEF00D_11111111, 0);
        access("wr21", 1, 0, 28'h0000021, 128'h12345678_00000021_87654321_22222222, 0);
        access("rd20_perturb", 0, 1, 28'h0000020, 128'd0, 1);

        for (int n = 0; n < 60; n++) begin
            ra = 28'($urandom);
            ra[IB-1:0] = 8'($urandom_range(0, 15));
            rd_data = {$urandom, $urandom, $urandom, $urandom};
            op = $urandom_range(0, 3);
            if (op != 1 && op != 3) last_wa = ra;
            access($sformatf("rand%0d_op%0d", n, op), op == 0 || op == 2,
                   op != 0, ra, rd_data, 0);
        end

        read = 1'b0; write = 1'b1; address = 28'h0000030; writedata = {16{8'h3C}};
        repeat (3) @(negedge clock);
        chk("midwr_busy_before", {127'd0, busywait}, 128'd1);
        reset = 1'b0;
        #1;
        chk("midwr_busy_async", {127'd0, busywait}, 128'd0);
        chk("midwr_rdata_async", readdata, 128'd0);
        model_reset();
        write = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_reset_busy", {127'd0, busywait}, 128'd0);
        access("rd30_after_reset", 0, 1, 28'h0000030, 128'd0, 0);
        access("rd_rand_after_reset", 0, 1, last_wa, 128'd0, 0);
        access("rd3_after_reset", 0, 1, 28'h0000003, 128'd0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
